// File: rtl/arithmetic_unit.sv
// arithmetic_unit: registered add/subtract with carry/borrow,
// signed overflow and zero flags, one cycle of latency.
module arithmetic_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             operation,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] addend;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result_nxt;
    logic             carry_nxt;
    logic             overflow_nxt;
    logic             zero_nxt;
    logic             a_msb;
    logic             b_msb;
    logic             r_msb;

    // Shared adder: subtraction feeds ~operand2 with a carry-in of 1.
    always_comb begin
        addend = operand2;
        cin    = 1'b0;
        unique case (1'b1)
            operation: begin
                addend = operand2;
                cin    = 1'b0;
            end
            !operation: begin
                addend = ~operand2;
                cin    = 1'b1;
            end
        endcase
        sum = {1'b0, operand1}
            + {1'b0, addend}
            + {{WIDTH{1'b0}}, cin};
        result_nxt = sum[MSB:0];
    end

    // Flags from the next result so they register alongside it.
    always_comb begin
        a_msb        = operand1[MSB];
        b_msb        = operand2[MSB];
        r_msb        = result_nxt[MSB];
        carry_nxt    = sum[WIDTH];
        overflow_nxt = 1'b0;
        unique case (1'b1)
            operation: begin
                carry_nxt    = sum[WIDTH];
                overflow_nxt = (a_msb == b_msb)
                             && (r_msb != a_msb);
            end
            !operation: begin
                carry_nxt    = ~sum[WIDTH];
                overflow_nxt = (a_msb != b_msb)
                             && (r_msb != a_msb);
            end
        endcase
        zero_nxt = (result_nxt == '0);
    end

    // Output registers; reset clears at once and discards in-flight work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            result    <= result_nxt;
            carry     <= carry_nxt;
            overflow  <= overflow_nxt;
            zero      <= zero_nxt;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arithmetic_unit.sv
// tb_arithmetic_unit: directed and randomized checks of
// arithmetic_unit against an integer reference model.
module tb_arithmetic_unit;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic         operation = 1'b1;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arithmetic_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    // {result, carry, overflow, zero, out_valid} from plain integer math
    function automatic logic [W+3:0] model(input int a, input int b,
                                           input bit op);
        int sa, sb, s, sr, r;
        bit c, v, z;
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        if (op) begin
            s  = a + b;
            c  = (s >= M);
            sr = sa + sb;
        end else begin
            s  = a - b;
            c  = (a < b);
            sr = sa - sb;
        end
        r = ((s % M) + M) % M;
        v = (sr > M / 2 - 1) || (sr < -(M / 2));
        z = (r == 0);
        return {r[W-1:0], c, v, z, 1'b1};
    endfunction

    function automatic logic [W+3:0] outs();
        return {result, carry, overflow, zero, out_valid};
    endfunction

    task automatic step(input int a, input int b, input bit op);
        operand1  = a[W-1:0];
        operand2  = b[W-1:0];
        operation = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W+3:0] want;
        want = {4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        operand1  = 4'd6;
        operand2  = 4'd3;
        operation = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL reset_now: got %b want %b", outs(), want);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (outs() !== want) begin
                n_bad++;
                $display("FAIL reset_hold%0d: got %b want %b",
                         i, outs(), want);
            end
        end
    endtask

    task automatic test_add();
        logic [W+3:0] want;
        @(negedge clk);
        reset = 1'b0;
        operand1  = 4'd6;
        operand2  = 4'd3;
        operation = 1'b1;
        @(posedge clk);
        #1;
        want = {4'd9, 1'b0, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL add_6_3: got %b want %b", outs(), want);
        end
    endtask

    task automatic test_sub();
        logic [W+3:0] want;
        step(9, 4, 1'b0);
        want = {4'd5, 1'b0, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL sub_9_4: got %b want %b", outs(), want);
        end
    endtask

    task automatic test_wrap();
        logic [W+3:0] want;
        step(15, 1, 1'b1);
        want = {4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL add_15_1: got %b want %b", outs(), want);
        end
        step(0, 1, 1'b0);
        want = {4'd15, 1'b1, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL sub_0_1: got %b want %b", outs(), want);
        end
        step(8, 1, 1'b0);
        want = {4'd7, 1'b0, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL sub_8_1: got %b want %b", outs(), want);
        end
        step(8, 8, 1'b1);
        want = {4'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL add_8_8: got %b want %b", outs(), want);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+3:0] want;
        step(3, 5, 1'b0);
        want = {4'd14, 1'b1, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL b2b_3_5: got %b want %b", outs(), want);
        end
        step(7, 7, 1'b0);
        want = {4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL b2b_7_7: got %b want %b", outs(), want);
        end
    endtask

    task automatic test_async_reset();
        logic [W+3:0] want;
        logic [W+3:0] clr;
        int a, b;
        bit op;
        clr = {4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        step(5, 6, 1'b1);
        @(negedge clk);
        operand1 = W'($urandom_range(M - 1));
        operand2 = W'($urandom_range(M - 1));
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== clr) begin
            n_bad++;
            $display("FAIL async_clear: got %b want %b", outs(), clr);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            operand1  = W'($urandom_range(M - 1));
            operand2  = W'($urandom_range(M - 1));
            operation = ~operation;
            n_cmp++;
            if (outs() !== clr) begin
                n_bad++;
                $display("FAIL async_hold%0d: got %b want %b",
                         i, outs(), clr);
            end
        end
        @(negedge clk);
        a  = int'($urandom_range(M - 1));
        b  = int'($urandom_range(M - 1));
        op = 1'($urandom_range(1));
        reset     = 1'b0;
        operand1  = a[W-1:0];
        operand2  = b[W-1:0];
        operation = op;
        @(posedge clk);
        #1;
        want = model(a, b, op);
        n_cmp++;
        if (outs() !== want) begin
            n_bad++;
            $display("FAIL async_release %0d,%0d,%0b: got %b want %b",
                     a, b, op, outs(), want);
        end
    endtask

    task automatic test_random();
        logic [W+3:0] want;
        int a, b;
        bit op;
        for (int i = 0; i < 300; i++) begin
            a  = int'($urandom_range(M - 1));
            b  = int'($urandom_range(M - 1));
            op = 1'($urandom_range(1));
            step(a, b, op);
            want = model(a, b, op);
            n_cmp++;
            if (outs() !== want) begin
                n_bad++;
                $display("FAIL rand%0d %0d,%0d,%0b: got %b want %b",
                         i, a, b, op, outs(), want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
